// File: rtl/eth_pkg.sv
// Shared Ethernet/IPv4/UDP framing constants and the framer state encoding.
package eth_pkg;

    localparam int unsigned ETH_HDR_LEN = 14;
    localparam int unsigned IP_HDR_LEN  = 20;
    localparam int unsigned UDP_HDR_LEN = 8;
    localparam int unsigned HDR_LEN     = ETH_HDR_LEN + IP_HDR_LEN + UDP_HDR_LEN;
    localparam int unsigned MIN_FRAME   = 60;

    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  IP_PROTO_UDP   = 8'h11;

    // Framer states (fixed encodings kept for compatibility with older tooling)
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_CSUM1   = 3'd1;
    localparam logic [2:0] ST_CSUM2   = 3'd2;
    localparam logic [2:0] ST_GRANT   = 3'd3;
    localparam logic [2:0] ST_HEADER  = 3'd4;
    localparam logic [2:0] ST_PAYLOAD = 3'd5;
    localparam logic [2:0] ST_PAD     = 3'd6;
    localparam logic [2:0] ST_DONE    = 3'd7;

    // One's-complement fold of a 32-bit partial sum, applied twice so that the
    // carry produced by the first fold is absorbed as well.
    function automatic logic [15:0] csum_fold(input logic [31:0] sum);
        logic [31:0] s1;
        logic [31:0] s2;
        s1 = {16'h0000, sum[15:0]} + {16'h0000, sum[31:16]};
        s2 = {16'h0000, s1[15:0]}  + {16'h0000, s1[31:16]};
        return s2[15:0];
    endfunction

endpackage

// File: rtl/ip_hdr_checksum.sv
// Two-stage IPv4 header checksum: stage 1 sums the header words, stage 2
// folds the carries and inverts.
module ip_hdr_checksum
    import eth_pkg::*;
#(
    parameter logic [7:0] IP_TTL = 8'h80
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        sum_en,
    input  logic        fold_en,
    input  logic [15:0] total_len,
    input  logic [15:0] ip_id,
    input  logic [31:0] src_ip,
    input  logic [31:0] dst_ip,
    output logic [15:0] csum
);

    logic [31:0] sum;

    // Sum the nine header words that can be nonzero; checksum field is zero
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sum  <= '0;
            csum <= '0;
        end else begin
            if (sum_en) begin
                sum <= 32'h0000_4500
                     + {16'h0000, total_len}
                     + {16'h0000, ip_id}
                     + 32'h0000_4000
                     + {16'h0000, IP_TTL, IP_PROTO_UDP}
                     + {16'h0000, src_ip[31:16]}
                     + {16'h0000, src_ip[15:0]}
                     + {16'h0000, dst_ip[31:16]}
                     + {16'h0000, dst_ip[15:0]};
            end
            if (fold_en) begin
                csum <= ~csum_fold(sum);
            end
        end
    end

endmodule

// File: rtl/udp_tx_framer.sv
// UDP transmit framer: grants one payload request at a time, prepends the
// Ethernet II / IPv4 / UDP headers, pads to the minimum frame size and streams
// bytes to the MAC under ready backpressure.
module udp_tx_framer
    import eth_pkg::*;
#(
    parameter logic [15:0] BASE_PORT   = 16'd1024,
    parameter logic [7:0]  IP_TTL      = 8'h80,
    parameter logic [15:0] MAX_PAYLOAD = 16'd1472
) (
    input  logic        tx_clock,
    input  logic        reset_n,
    input  logic [47:0] local_mac,
    input  logic [31:0] local_ip,
    input  logic [47:0] dest_mac,
    input  logic [31:0] dest_ip,
    input  logic [15:0] dest_port,
    input  logic        udp_tx_request,
    input  logic [15:0] udp_tx_length,
    input  logic [7:0]  port_ID,
    input  logic [7:0]  udp_tx_data,
    output logic        udp_tx_enable,
    output logic        udp_tx_active,
    input  logic        mac_tx_ready,
    output logic        mac_tx_valid,
    output logic [7:0]  mac_tx_data,
    output logic        mac_tx_sop,
    output logic        mac_tx_eop,
    output logic        length_err
);

    localparam logic [16:0] POS_HDR_LAST = 17'(HDR_LEN - 1);
    localparam logic [16:0] POS_PAD_LAST = 17'(MIN_FRAME - 1);
    localparam logic [16:0] MIN_FRAME_W  = 17'(MIN_FRAME);
    localparam logic [16:0] HDR_LEN_W    = 17'(HDR_LEN);

    logic [2:0]  state;
    logic [15:0] len_q;
    logic [15:0] sport_q;
    logic [15:0] id_q;
    logic [15:0] ip_id;
    logic        armed;
    logic [16:0] pos;
    logic [15:0] csum;

    logic [16:0] end_pos;
    logic [15:0] ip_total_len;
    logic [15:0] udp_len;
    logic        short_frame;
    logic        last_payload;
    logic [7:0]  hdr_byte;

    assign end_pos      = {1'b0, len_q} + HDR_LEN_W;
    assign ip_total_len = len_q + 16'(IP_HDR_LEN + UDP_HDR_LEN);
    assign udp_len      = len_q + 16'(UDP_HDR_LEN);
    assign short_frame  = end_pos < MIN_FRAME_W;
    assign last_payload = pos == (end_pos - 17'd1);

    ip_hdr_checksum #(
        .IP_TTL (IP_TTL)
    ) u_csum (
        .clk       (tx_clock),
        .reset_n   (reset_n),
        .sum_en    (state == ST_CSUM1),
        .fold_en   (state == ST_CSUM2),
        .total_len (ip_total_len),
        .ip_id     (id_q),
        .src_ip    (local_ip),
        .dst_ip    (dest_ip),
        .csum      (csum)
    );

    // Frame sequencing, request arming, ip_id counter and sticky length error
    always_ff @(posedge tx_clock) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            len_q      <= '0;
            sport_q    <= '0;
            id_q       <= '0;
            ip_id      <= '0;
            armed      <= 1'b1;
            pos        <= '0;
            length_err <= 1'b0;
        end else begin
            if (!udp_tx_request) begin
                armed <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (udp_tx_request && armed) begin
                        len_q   <= udp_tx_length;
                        sport_q <= BASE_PORT + {8'h00, port_ID};
                        id_q    <= ip_id;
                        armed   <= 1'b0;
                        if (udp_tx_length > MAX_PAYLOAD) begin
                            length_err <= 1'b1;
                        end
                        state <= ST_CSUM1;
                    end
                end
                ST_CSUM1: state <= ST_CSUM2;
                ST_CSUM2: state <= ST_GRANT;
                ST_GRANT: begin
                    pos   <= '0;
                    state <= ST_HEADER;
                end
                ST_HEADER: begin
                    if (mac_tx_ready) begin
                        pos <= pos + 17'd1;
                        if (pos == POS_HDR_LAST) begin
                            state <= (len_q == 16'd0) ? ST_PAD : ST_PAYLOAD;
                        end
                    end
                end
                ST_PAYLOAD: begin
                    if (mac_tx_ready) begin
                        pos <= pos + 17'd1;
                        if (last_payload) begin
                            state <= short_frame ? ST_PAD : ST_DONE;
                        end
                    end
                end
                ST_PAD: begin
                    if (mac_tx_ready) begin
                        pos <= pos + 17'd1;
                        if (pos == POS_PAD_LAST) begin
                            state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    ip_id <= ip_id + 16'd1;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Header byte selected by frame position (all fields big-endian)
    always_comb begin
        hdr_byte = 8'h00;
        case (pos[5:0])
            6'd0:  hdr_byte = dest_mac[47:40];
            6'd1:  hdr_byte = dest_mac[39:32];
            6'd2:  hdr_byte = dest_mac[31:24];
            6'd3:  hdr_byte = dest_mac[23:16];
            6'd4:  hdr_byte = dest_mac[15:8];
            6'd5:  hdr_byte = dest_mac[7:0];
            6'd6:  hdr_byte = local_mac[47:40];
            6'd7:  hdr_byte = local_mac[39:32];
            6'd8:  hdr_byte = local_mac[31:24];
            6'd9:  hdr_byte = local_mac[23:16];
            6'd10: hdr_byte = local_mac[15:8];
            6'd11: hdr_byte = local_mac[7:0];
            6'd12: hdr_byte = ETHERTYPE_IPV4[15:8];
            6'd13: hdr_byte = ETHERTYPE_IPV4[7:0];
            6'd14: hdr_byte = 8'h45;
            6'd15: hdr_byte = 8'h00;
            6'd16: hdr_byte = ip_total_len[15:8];
            6'd17: hdr_byte = ip_total_len[7:0];
            6'd18: hdr_byte = id_q[15:8];
            6'd19: hdr_byte = id_q[7:0];
            6'd20: hdr_byte = 8'h40;
            6'd21: hdr_byte = 8'h00;
            6'd22: hdr_byte = IP_TTL;
            6'd23: hdr_byte = IP_PROTO_UDP;
            6'd24: hdr_byte = csum[15:8];
            6'd25: hdr_byte = csum[7:0];
            6'd26: hdr_byte = local_ip[31:24];
            6'd27: hdr_byte = local_ip[23:16];
            6'd28: hdr_byte = local_ip[15:8];
            6'd29: hdr_byte = local_ip[7:0];
            6'd30: hdr_byte = dest_ip[31:24];
            6'd31: hdr_byte = dest_ip[23:16];
            6'd32: hdr_byte = dest_ip[15:8];
            6'd33: hdr_byte = dest_ip[7:0];
            6'd34: hdr_byte = sport_q[15:8];
            6'd35: hdr_byte = sport_q[7:0];
            6'd36: hdr_byte = dest_port[15:8];
            6'd37: hdr_byte = dest_port[7:0];
            6'd38: hdr_byte = udp_len[15:8];
            6'd39: hdr_byte = udp_len[7:0];
            default: hdr_byte = 8'h00;
        endcase
    end

    // Output decode from state; holding pos under !ready keeps outputs stable
    always_comb begin
        udp_tx_enable = 1'b0;
        udp_tx_active = 1'b0;
        mac_tx_valid  = 1'b0;
        mac_tx_data   = 8'h00;
        mac_tx_sop    = 1'b0;
        mac_tx_eop    = 1'b0;
        case (state)
            ST_GRANT: udp_tx_enable = 1'b1;
            ST_HEADER: begin
                mac_tx_valid = 1'b1;
                mac_tx_data  = hdr_byte;
                mac_tx_sop   = (pos == 17'd0);
            end
            ST_PAYLOAD: begin
                mac_tx_valid  = 1'b1;
                mac_tx_data   = udp_tx_data;
                udp_tx_active = mac_tx_ready;
                mac_tx_eop    = last_payload && !short_frame;
            end
            ST_PAD: begin
                mac_tx_valid = 1'b1;
                mac_tx_eop   = (pos == POS_PAD_LAST);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_udp_tx_framer.sv
// Directed self-checking bench for udp_tx_framer.
module tb_udp_tx_framer;

    logic        tx_clock = 1'b0;
    logic        reset_n;
    logic [47:0] local_mac = 48'h02_00_00_AA_BB_CC;
    logic [31:0] local_ip  = 32'hC0A8_0164;
    logic [47:0] dest_mac  = 48'h00_1C_42_11_22_33;
    logic [31:0] dest_ip   = 32'hC0A8_010A;
    logic [15:0] dest_port = 16'd1025;
    logic        udp_tx_request = 1'b0;
    logic [15:0] udp_tx_length  = 16'd0;
    logic [7:0]  port_ID = 8'd0;
    logic [7:0]  udp_tx_data = 8'h00;
    logic        udp_tx_enable;
    logic        udp_tx_active;
    logic        mac_tx_ready = 1'b1;
    logic        mac_tx_valid;
    logic [7:0]  mac_tx_data;
    logic        mac_tx_sop;
    logic        mac_tx_eop;
    logic        length_err;

    always #5 tx_clock = ~tx_clock;

    udp_tx_framer #(
        .BASE_PORT   (16'd1024),
        .IP_TTL      (8'h80),
        .MAX_PAYLOAD (16'd1472)
    ) dut (
        .tx_clock       (tx_clock),
        .reset_n        (reset_n),
        .local_mac      (local_mac),
        .local_ip       (local_ip),
        .dest_mac       (dest_mac),
        .dest_ip        (dest_ip),
        .dest_port      (dest_port),
        .udp_tx_request (udp_tx_request),
        .udp_tx_length  (udp_tx_length),
        .port_ID        (port_ID),
        .udp_tx_data    (udp_tx_data),
        .udp_tx_enable  (udp_tx_enable),
        .udp_tx_active  (udp_tx_active),
        .mac_tx_ready   (mac_tx_ready),
        .mac_tx_valid   (mac_tx_valid),
        .mac_tx_data    (mac_tx_data),
        .mac_tx_sop     (mac_tx_sop),
        .mac_tx_eop     (mac_tx_eop),
        .length_err     (length_err)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Monitor state, updated on the falling edge
    int          cyc = 0;
    int          nbytes, sop_pos, eop_pos, eop_cnt, n_active, grants, grant_cyc, stall_err;
    logic [7:0]  frame [0:4095];
    bit          consumed = 1'b0;
    bit          prev_stall = 1'b0;
    logic [7:0]  prev_data;
    logic        prev_sop, prev_eop;

    // Sender / MAC model state
    bit          stall_en = 1'b0;
    logic [7:0]  seed = 8'h00;
    int          pidx = 0;

    function automatic logic [7:0] pay_byte(input int i, input logic [7:0] s);
        return 8'(i * 13) ^ s;
    endfunction

    always @(negedge tx_clock) begin
        cyc++;
        if (udp_tx_enable) begin
            grants++;
            grant_cyc = cyc;
        end
        if (prev_stall && (!mac_tx_valid || mac_tx_data !== prev_data ||
                           mac_tx_sop !== prev_sop || mac_tx_eop !== prev_eop))
            stall_err++;
        if (!mac_tx_ready && udp_tx_active) stall_err++;
        prev_stall = mac_tx_valid && !mac_tx_ready;
        prev_data  = mac_tx_data;
        prev_sop   = mac_tx_sop;
        prev_eop   = mac_tx_eop;
        if (mac_tx_valid && mac_tx_ready) begin
            if (nbytes < 4096) frame[nbytes] = mac_tx_data;
            if (mac_tx_sop) sop_pos = nbytes;
            if (mac_tx_eop) begin
                eop_pos = nbytes;
                eop_cnt++;
            end
            nbytes++;
        end
        consumed = udp_tx_active;
        if (udp_tx_active) n_active++;
    end

    always @(posedge tx_clock) begin
        #1;
        if (consumed) pidx++;
        udp_tx_data  = pay_byte(pidx, seed);
        mac_tx_ready = stall_en ? ~mac_tx_ready : 1'b1;
    end

    task automatic clear_mon();
        nbytes = 0; sop_pos = -1; eop_pos = -1; eop_cnt = 0;
        n_active = 0; grants = 0; grant_cyc = -1; stall_err = 0;
        pidx = 0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        udp_tx_request = 1'b0;
        repeat (3) @(posedge tx_clock);
        #1 reset_n = 1'b1;
    endtask

    // Issue a request and wait (bounded) until the frame's eop byte is taken
    // and the framer has passed back through DONE.
    task automatic run_frame(input int len, input bit hold, input bit chk_lat, input string tag);
        int req_cyc;
        clear_mon();
        @(posedge tx_clock);
        #1;
        udp_tx_length  = 16'(len);
        udp_tx_request = 1'b1;
        req_cyc = cyc + 1;
        for (int i = 0; i < 3 * len + 300; i++) begin
            @(negedge tx_clock);
            #1;
            if (eop_cnt > 0) break;
        end
        if (eop_cnt == 0) check({tag, "_timeout"}, 32'd0, 32'd1);
        @(posedge tx_clock);
        @(posedge tx_clock);
        #1;
        if (!hold) udp_tx_request = 1'b0;
        if (chk_lat) check({tag, "_grant_latency"}, 32'(grant_cyc - req_cyc), 32'd3);
    endtask

    // Compare the captured frame against an independently assembled header,
    // the known payload pattern and zero padding.
    task automatic check_frame(input int len, input logic [15:0] id, input string tag);
        logic [159:0] ip;
        logic [335:0] h;
        logic [31:0]  sum;
        int total, bad_hdr, bad_pay, bad_pad;
        ip  = {8'h45, 8'h00, 16'(28 + len), id, 16'h4000, 8'h80, 8'h11, 16'h0000, local_ip, dest_ip};
        sum = 0;
        for (int w = 0; w < 10; w++) sum = sum + 32'(ip[159 - 16 * w -: 16]);
        while (sum[31:16] != 0) sum = {16'h0, sum[15:0]} + {16'h0, sum[31:16]};
        ip[79:64] = ~sum[15:0];
        h = {dest_mac, local_mac, 16'h0800, ip, 16'(1024 + int'(port_ID)), dest_port,
             16'(8 + len), 16'h0000};
        total   = (42 + len < 60) ? 60 : 42 + len;
        bad_hdr = 0; bad_pay = 0; bad_pad = 0;
        for (int k = 0; k < 42; k++)
            if (frame[k] !== h[335 - 8 * k -: 8]) bad_hdr++;
        for (int k = 0; k < len; k++)
            if (frame[42 + k] !== pay_byte(k, seed)) bad_pay++;
        for (int k = 42 + len; k < total; k++)
            if (frame[k] !== 8'h00) bad_pad++;
        check({tag, "_nbytes"},   32'(nbytes),   32'(total));
        check({tag, "_sop_pos"},  32'(sop_pos),  32'd0);
        check({tag, "_eop_pos"},  32'(eop_pos),  32'(total - 1));
        check({tag, "_eop_cnt"},  32'(eop_cnt),  32'd1);
        check({tag, "_active"},   32'(n_active), 32'(len));
        check({tag, "_grants"},   32'(grants),   32'd1);
        check({tag, "_hdr_bad"},  32'(bad_hdr),  32'd0);
        check({tag, "_pay_bad"},  32'(bad_pay),  32'd0);
        check({tag, "_pad_bad"},  32'(bad_pad),  32'd0);
        check({tag, "_stall"},    32'(stall_err), 32'd0);
    endtask

    initial begin
        int zeros;
        bit seen;
        do_reset();
        reset_n = 1'b0;
        @(negedge tx_clock);
        check("rst_valid",  {31'd0, mac_tx_valid},  32'd0);
        check("rst_enable", {31'd0, udp_tx_enable}, 32'd0);
        check("rst_active", {31'd0, udp_tx_active}, 32'd0);
        check("rst_sop_eop", {30'd0, mac_tx_sop, mac_tx_eop}, 32'd0);
        check("rst_lerr",   {31'd0, length_err},    32'd0);
        @(posedge tx_clock);
        #1 reset_n = 1'b1;

        // 1: L=60, ip_id 0, known checksum 0x76D6
        seed = 8'h5A; port_ID = 8'd0;
        run_frame(60, 1'b0, 1'b1, "t1");
        check_frame(60, 16'h0000, "t1");
        check("t1_csum",  {16'h0, frame[24], frame[25]}, 32'h76D6);
        check("t1_total", {16'h0, frame[16], frame[17]}, 32'h0058);

        // 2: source port offset
        port_ID = 8'd11; seed = 8'hC3;
        run_frame(100, 1'b0, 1'b1, "t2");
        check_frame(100, 16'h0001, "t2");
        check("t2_sport",   {16'h0, frame[34], frame[35]}, 32'h040B);
        check("t2_udp_len", {16'h0, frame[38], frame[39]}, 32'd108);

        // 3: short payload padded to 60
        seed = 8'h11;
        run_frame(4, 1'b0, 1'b1, "t3");
        check_frame(4, 16'h0002, "t3");
        zeros = 0;
        for (int k = 46; k < 60; k++) if (frame[k] === 8'h00) zeros++;
        check("t3_pad_zeros", 32'(zeros), 32'd14);

        // 4: 50% backpressure over a long payload
        seed = 8'hA7; stall_en = 1'b1;
        run_frame(1024, 1'b0, 1'b0, "t4");
        stall_en = 1'b0;
        check_frame(1024, 16'h0003, "t4");

        // 5: held request not re-granted; ip_id sequence and wrap
        do_reset();
        seed = 8'h3C;
        run_frame(20, 1'b1, 1'b1, "t5a");
        check_frame(20, 16'h0000, "t5a");
        repeat (20) @(posedge tx_clock);
        check("t5_hold_no_regrant", 32'(grants), 32'd1);
        #1 udp_tx_request = 1'b0;
        run_frame(20, 1'b0, 1'b1, "t5b");
        check_frame(20, 16'h0001, "t5b");
        run_frame(20, 1'b0, 1'b1, "t5c");
        check_frame(20, 16'h0002, "t5c");
        @(posedge tx_clock);
        #1 force dut.ip_id = 16'hFFFF;
        @(posedge tx_clock);
        #1 release dut.ip_id;
        run_frame(20, 1'b0, 1'b1, "t5d");
        check_frame(20, 16'hFFFF, "t5d");
        run_frame(20, 1'b0, 1'b1, "t5e");
        check_frame(20, 16'h0000, "t5e");

        // 6: reset while header byte 20 is on the bus, then oversize payload
        clear_mon();
        @(posedge tx_clock);
        #1;
        udp_tx_length  = 16'd30;
        udp_tx_request = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge tx_clock);
            #1;
            if (nbytes == 21) begin
                seen = 1'b1;
                break;
            end
        end
        check("t6_reached_byte20", {31'd0, seen}, 32'd1);
        check("t6_byte20_valid", {31'd0, mac_tx_valid}, 32'd1);
        reset_n = 1'b0;
        @(negedge tx_clock);
        check("t6_abort_valid",  {31'd0, mac_tx_valid},  32'd0);
        check("t6_abort_active", {31'd0, udp_tx_active}, 32'd0);
        check("t6_abort_enable", {31'd0, udp_tx_enable}, 32'd0);
        check("t6_abort_eop",    {31'd0, mac_tx_eop},    32'd0);
        @(posedge tx_clock);
        #1;
        reset_n = 1'b1;
        udp_tx_request = 1'b0;
        @(posedge tx_clock);
        check("t6_lerr_clear", {31'd0, length_err}, 32'd0);
        seed = 8'h99; port_ID = 8'd3;
        run_frame(2000, 1'b0, 1'b1, "t6");
        check_frame(2000, 16'h0000, "t6");
        check("t6_lerr_set", {31'd0, length_err}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
